// File: rtl/timer_ccu_pkg.sv
// timer_ccu_pkg: register map, bit indices and CTRL layout
// shared by the timer compare/capture unit and its channels.
package timer_ccu_pkg;

  localparam int NUM_CH = 2;

  localparam logic [4:0] ADDR_CTRL   = 5'h00;
  localparam logic [4:0] ADDR_STATUS = 5'h04;
  localparam logic [4:0] ADDR_CCR0   = 5'h08;
  localparam logic [4:0] ADDR_CCR1   = 5'h0C;
  localparam logic [4:0] ADDR_CAP    = 5'h10;

  localparam int CTRL_EN0    = 0;
  localparam int CTRL_EN1    = 1;
  localparam int CTRL_POL0   = 2;
  localparam int CTRL_POL1   = 3;
  localparam int CTRL_IE_M0  = 4;
  localparam int CTRL_IE_M1  = 5;
  localparam int CTRL_IE_OVF = 6;
  localparam int CTRL_IE_CAP = 7;

  localparam int ST_M0F  = 0;
  localparam int ST_M1F  = 1;
  localparam int ST_OVF  = 2;
  localparam int ST_CAPF = 3;

  typedef struct packed {
    logic              ie_cap;
    logic              ie_ovf;
    logic [NUM_CH-1:0] ie_m;
    logic [NUM_CH-1:0] pol;
    logic [NUM_CH-1:0] en;
  } ctrl_t;

  function automatic logic [4:0] ccr_addr(input int n);
    return ADDR_CCR0 + 5'(n << 2);
  endfunction

endpackage

// File: rtl/timer_ccu_channel.sv
// ccu_channel: one compare channel with shadow/active CCR,
// registered PWM output and count-step match detect.
module ccu_channel
  import timer_ccu_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        pol_i,
  input  logic        wr_i,
  input  logic [31:0] wdata_i,
  input  logic        upd_i,
  input  logic        step_i,
  input  logic [31:0] tcnt_i,
  output logic [31:0] shadow_o,
  output logic        pwm_o,
  output logic        match_o
);

  logic [31:0] shadow_q;
  logic [31:0] shadow_d;
  logic [31:0] act_q;
  logic [31:0] act_d;
  logic        pwm_q;
  logic        pwm_d;
  logic        cmp;

  // next-state: shadow takes writes, active follows
  // shadow on update or while disabled
  always_comb begin
    cmp      = tcnt_i < act_q;
    shadow_d = wr_i ? wdata_i : shadow_q;
    act_d    = (upd_i || !en_i) ? shadow_q : act_q;
    pwm_d    = en_i ? (cmp ^ pol_i) : pol_i;
  end

  // channel state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
      act_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      act_q    <= act_d;
      pwm_q    <= pwm_d;
    end
  end

  assign shadow_o = shadow_q;
  assign pwm_o    = pwm_q;
  assign match_o  = step_i & en_i & (tcnt_i == act_q);

endmodule

// File: rtl/timer_ccu.sv
// timer_ccu: APB compare/PWM unit with optional capture
// (capture built only with TIMER_CCU_CAPTURE_EN defined).
module timer_ccu
  import timer_ccu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [4:0]  PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  input  logic [31:0] tcnt,
  input  logic [31:0] arr,
  input  logic        cap_i,
  output logic [1:0]  pwm_o,
  output logic        irq
);

  ctrl_t       ctrl_q;
  ctrl_t       ctrl_d;
  logic [7:0]  ctrl_v;
  logic [7:0]  ctrl_dv;
  logic [3:0]  status_q;
  logic [3:0]  status_d;
  logic [3:0]  st_set;
  logic [3:0]  st_clr;
  logic [3:0]  ie;
  logic [31:0] tcnt_q;
  logic        setup_q;
  logic        pready_q;
  logic        irq_q;
  logic        irq_d;
  logic        acc;
  logic        commit;
  logic        wr_en;
  logic        rd_en;
  logic        sel_ctrl;
  logic        sel_status;
  logic        sel_ccr0;
  logic        sel_ccr1;
  logic        sel_cap;
  logic        step;
  logic        upd;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] pwm;
  logic [31:0] shadow [NUM_CH];
  logic        cap_rise;
  logic [31:0] cap_val;
  logic [31:0] rdata;

  // a transfer only commits if its setup phase was seen
  // after reset, so an access cut by reset is dropped
  assign acc    = PSEL & PENABLE;
  assign commit = acc & setup_q;
  assign wr_en  = commit & PWRITE;
  assign rd_en  = acc & ~PWRITE;

  assign sel_ctrl   = PADDR == ADDR_CTRL;
  assign sel_status = PADDR == ADDR_STATUS;
  assign sel_ccr0   = PADDR == ADDR_CCR0;
  assign sel_ccr1   = PADDR == ADDR_CCR1;
  assign sel_cap    = PADDR == ADDR_CAP;

  assign step = tcnt != tcnt_q;
  assign upd  = step & (tcnt == '0) & (tcnt_q == arr);

  assign ctrl_v = ctrl_q;
  assign ctrl_d = ctrl_dv;

`ifdef TIMER_CCU_CAPTURE_EN
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   cap_prev_q;
  logic [31:0]            cap_q;

  // synchronize cap_i, detect rising edge, latch tcnt
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      sync_q     <= '0;
      cap_prev_q <= 1'b0;
      cap_q      <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], cap_i};
      cap_prev_q <= sync_q[SYNC_STAGES-1];
      if (cap_rise) begin
        cap_q <= tcnt;
      end
    end
  end

  assign cap_rise = sync_q[SYNC_STAGES-1] & ~cap_prev_q;
  assign cap_val  = cap_q;
`else
  logic cap_unused;
  assign cap_unused = cap_i ^ (SYNC_STAGES > 3);
  assign cap_rise   = 1'b0;
  assign cap_val    = '0;
`endif

  // CTRL/STATUS next state; a flag set beats a same-edge clear
  always_comb begin
    ctrl_dv = (wr_en && sel_ctrl) ? PWDATA[7:0] : ctrl_v;
    st_set          = '0;
    st_set[ST_M0F]  = match[0];
    st_set[ST_M1F]  = match[1];
    st_set[ST_OVF]  = upd;
    st_set[ST_CAPF] = cap_rise;
    st_clr   = (wr_en && sel_status) ? PWDATA[3:0] : '0;
    status_d = (status_q & ~st_clr) | st_set;
    ie          = '0;
    ie[ST_M0F]  = ctrl_v[CTRL_IE_M0];
    ie[ST_M1F]  = ctrl_v[CTRL_IE_M1];
    ie[ST_OVF]  = ctrl_v[CTRL_IE_OVF];
    ie[ST_CAPF] = ctrl_v[CTRL_IE_CAP];
    irq_d = |(status_q & ie);
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    localparam int EnIdx  = (n == 0) ? CTRL_EN0 : CTRL_EN1;
    localparam int PolIdx = (n == 0) ? CTRL_POL0 : CTRL_POL1;

    ccu_channel u_ch (
      .clk_i    (PCLK),
      .rst_ni   (PRESET),
      .en_i     (ctrl_dv[EnIdx]),
      .pol_i    (ctrl_dv[PolIdx]),
      .wr_i     (wr_en && (PADDR == ccr_addr(n))),
      .wdata_i  (PWDATA),
      .upd_i    (upd),
      .step_i   (step),
      .tcnt_i   (tcnt),
      .shadow_o (shadow[n]),
      .pwm_o    (pwm[n]),
      .match_o  (match[n])
    );
  end

  // combinational read mux, zero outside a read access
  always_comb begin
    rdata = '0;
    if (rd_en) begin
      unique case (1'b1)
        sel_ctrl:   rdata = {24'h0, ctrl_v};
        sel_status: rdata = {28'h0, status_q};
        sel_ccr0:   rdata = shadow[0];
        sel_ccr1:   rdata = shadow[1];
        sel_cap:    rdata = cap_val;
        default:    rdata = '0;
      endcase
    end
  end

  // control, status, handshake and irq registers
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      ctrl_q   <= '0;
      status_q <= '0;
      tcnt_q   <= '0;
      setup_q  <= 1'b0;
      pready_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      tcnt_q   <= tcnt;
      setup_q  <= PSEL & ~PENABLE;
      pready_q <= commit;
      irq_q    <= irq_d;
    end
  end

  assign PRDATA = rdata;
  assign PREADY = pready_q;
  assign irq    = irq_q;
  assign pwm_o  = pwm;

endmodule
